// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: sequential 16-bit instruction prefetcher with credit-limited in-flight reads,
// a PC-tagged FIFO toward rf_read, and redirect flush that drops stale in-flight responses.
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic        i_mem_waitrequest,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_rddatavalid,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    typedef enum logic {RUN, STALL} state_t;
    state_t state_q, state_d;
    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [15:0] fetch_q, fetch_d, resp_q, resp_d, pend_pc_q, pend_pc_d;
    logic pend_q, pend_d, acc, dropping, push, pop;
    logic [CW:0] used;
    assign used = {1'b0, count_q} + {1'b0, out_q};
    assign o_mem_addr = fetch_q;
    assign o_valid = count_q != '0;
    assign o_instr = mem_q[rd_q][15:0];
    assign o_instr_pc = mem_q[rd_q][31:16];
    always_comb begin
        fetch_d = fetch_q;
        pend_d = pend_q;
        pend_pc_d = pend_pc_q;
        o_mem_rd = !reset && (state_q == STALL || (used < DEPTH_C && !i_redirect));
        acc = o_mem_rd && !i_mem_waitrequest;
        dropping = i_mem_rddatavalid && drop_q != '0;
        push = i_mem_rddatavalid && !dropping && !i_redirect;
        pop = o_valid && i_ready && !i_redirect;
        out_d = out_q + CW'(acc) - CW'(i_mem_rddatavalid);
        // every read still in flight after a redirect belongs to the old path
        drop_d = i_redirect ? out_d : drop_q - CW'(dropping) + CW'(acc && pend_q);
        count_d = i_redirect ? '0 : count_q + CW'(push) - CW'(pop);
        resp_d = i_redirect ? i_redirect_pc : (push ? resp_q + 16'd2 : resp_q);
        state_d = (o_mem_rd && i_mem_waitrequest) ? STALL : RUN;
        if (acc) begin
            fetch_d = i_redirect ? i_redirect_pc : (pend_q ? pend_pc_q : fetch_q + 16'd2);
            pend_d = 1'b0;
        end else if (i_redirect) begin
            if (state_q == STALL) begin
                pend_d = 1'b1;
                pend_pc_d = i_redirect_pc;
            end else begin
                fetch_d = i_redirect_pc;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
            out_q <= '0;
            drop_q <= '0;
            fetch_q <= RESET_PC;
            resp_q <= RESET_PC;
            pend_q <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (push) mem_q[wr_q] <= {resp_q, i_mem_rddata};
            rd_q <= i_redirect ? '0 : rd_q + AW'(pop);
            wr_q <= i_redirect ? '0 : wr_q + AW'(push);
            count_q <= count_d;
            out_q <= out_d;
            drop_q <= drop_d;
            fetch_q <= fetch_d;
            resp_q <= resp_d;
            pend_q <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) assert (used <= DEPTH_C);
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue: directed vector table plus hand sequences, with an in-order
// variable-latency memory model and a PC/data pairing scoreboard on every pop.
module tb_ifetch_prefetch_queue;
    logic clk, reset, wt, rdvalid, redir, ready;
    logic [15:0] rddata, rpc, mem_addr, instr, instr_pc;
    logic mem_rd, valid;

    ifetch_prefetch_queue dut (
        .clk(clk), .reset(reset),
        .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .i_mem_waitrequest(wt),
        .i_mem_rddata(rddata), .i_mem_rddatavalid(rdvalid),
        .i_redirect(redir), .i_redirect_pc(rpc),
        .o_valid(valid), .o_instr(instr), .o_instr_pc(instr_pc), .i_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [15:0] a; int due;} req_t;
    typedef struct {
        logic seg, wt, rdy, rdr;
        logic [15:0] rpc;
        logic erd;
        logic [15:0] eaddr;
        logic ev;
        logic [15:0] epc;
    } vec_t;

    req_t q[$];
    logic [15:0] pops[$];
    int n_chk = 0, n_err = 0, cyc = 0, lat = 1, last_due = 0;
    logic rnd = 1'b0, acc_s;
    logic [15:0] a_s, exp_pc;
    vec_t tv[14];

    function automatic logic [15:0] f(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic pre();
        @(negedge clk);
        acc_s = mem_rd && !wt;
        a_s = mem_addr;
        if (!reset) begin
            if (redir) exp_pc = rpc;
            else if (valid && ready) begin
                chk("sb_pc", instr_pc, exp_pc);
                chk("sb_data", instr, f(exp_pc));
                pops.push_back(instr_pc);
                exp_pc = exp_pc + 16'd2;
            end
        end
    endtask

    task automatic post();
        int l, due;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            q.delete();
            last_due = 0;
        end else if (acc_s) begin
            l = rnd ? int'($urandom_range(1, 4)) : lat;
            due = cyc - 1 + l;
            if (due < last_due) due = last_due;
            q.push_back('{a_s, due});
            last_due = due;
        end
        rdvalid = 1'b0;
        rddata = 16'h0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            rdvalid = 1'b1;
            rddata = f(q[0].a);
            void'(q.pop_front());
        end
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic do_reset();
        reset = 1'b1; wt = 1'b0; redir = 1'b0; ready = 1'b0; rpc = 16'h0;
        step();
        step();
        pre();
        chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        post();
        reset = 1'b0;
        exp_pc = 16'h0;
    endtask

    task automatic wait_valid(input int bound);
        for (int n = 0; n < bound && !valid; n++) step();
        chk("wait_valid", valid, 1);
    endtask

    initial begin
        tv = '{
            '{1,0,1,0,16'h0, 1,16'd0,0,16'd0},
            '{0,0,1,0,16'h0, 1,16'd2,0,16'd0},
            '{0,0,1,0,16'h0, 1,16'd4,1,16'd0},
            '{0,0,1,0,16'h0, 1,16'd6,1,16'd2},
            '{0,0,1,0,16'h0, 1,16'd8,1,16'd4},
            '{0,0,1,0,16'h0, 1,16'd10,1,16'd6},
            '{1,0,0,0,16'h0, 1,16'd0,0,16'd0},
            '{0,0,0,0,16'h0, 1,16'd2,0,16'd0},
            '{0,0,0,0,16'h0, 1,16'd4,1,16'd0},
            '{0,0,0,0,16'h0, 1,16'd6,1,16'd0},
            '{0,0,0,0,16'h0, 0,16'd8,1,16'd0},
            '{0,0,0,0,16'h0, 0,16'd8,1,16'd0},
            '{0,0,1,0,16'h0, 0,16'd8,1,16'd0},
            '{0,0,1,0,16'h0, 1,16'd8,1,16'd2}
        };
        reset = 1'b1; wt = 1'b0; redir = 1'b0; ready = 1'b0; rpc = 16'h0;
        rdvalid = 1'b0; rddata = 16'h0; exp_pc = 16'h0;
        lat = 1;
        for (int i = 0; i < $size(tv); i++) begin
            if (tv[i].seg) do_reset();
            wt = tv[i].wt; ready = tv[i].rdy; redir = tv[i].rdr; rpc = tv[i].rpc;
            pre();
            chk($sformatf("v%0d_rd", i), mem_rd, tv[i].erd);
            chk($sformatf("v%0d_addr", i), mem_addr, tv[i].eaddr);
            chk($sformatf("v%0d_valid", i), valid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("v%0d_pc", i), instr_pc, tv[i].epc);
            post();
        end

        // three reads in flight when the redirect lands
        do_reset();
        lat = 3; ready = 1'b1;
        repeat (3) step();
        redir = 1'b1; rpc = 16'h0040;
        pre();
        chk("t3_rd_in_redirect", mem_rd, 0);
        post();
        redir = 1'b0;
        wait_valid(20);
        chk("t3_first_pc", instr_pc, 16'h0040);
        chk("t3_first_data", instr, f(16'h0040));
        step();
        chk("t3_second_pc", instr_pc, 16'h0042);

        // redirect while a request is held by waitrequest
        do_reset();
        lat = 1; ready = 1'b1; wt = 1'b1;
        pre(); chk("t4_rd0", mem_rd, 1); chk("t4_addr0", mem_addr, 16'h0); post();
        pre(); chk("t4_addr1", mem_addr, 16'h0); post();
        redir = 1'b1; rpc = 16'h0100;
        pre(); chk("t4_rd2", mem_rd, 1); chk("t4_addr2", mem_addr, 16'h0); post();
        redir = 1'b0; wt = 1'b0;
        pre(); chk("t4_addr3", mem_addr, 16'h0); post();
        pre(); chk("t4_rd4", mem_rd, 1); chk("t4_addr4", mem_addr, 16'h0100); post();
        wait_valid(20);
        chk("t4_first_pc", instr_pc, 16'h0100);
        chk("t4_first_data", instr, f(16'h0100));

        // redirect and pop in the same cycle with the FIFO full
        do_reset();
        lat = 1; ready = 1'b0;
        repeat (6) step();
        ready = 1'b1; redir = 1'b1; rpc = 16'h0200;
        pre(); chk("t5_full_valid", valid, 1); chk("t5_rd", mem_rd, 0); post();
        redir = 1'b0;
        chk("t5_flushed", valid, 0);
        wait_valid(20);
        chk("t5_first_pc", instr_pc, 16'h0200);

        // PC wrap under random latency, waitrequest and back-pressure
        do_reset();
        rnd = 1'b1; ready = 1'b1;
        redir = 1'b1; rpc = 16'hFFFC;
        step();
        redir = 1'b0;
        pops.delete();
        repeat (40) begin
            wt = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("t6_pop_count", pops.size() >= 4, 1);
        chk("t6_pc0", pops[0], 16'hFFFC);
        chk("t6_pc1", pops[1], 16'hFFFE);
        chk("t6_pc2", pops[2], 16'h0000);
        chk("t6_pc3", pops[3], 16'h0002);
        repeat (120) begin
            wt = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom) & 16'hFFFE;
            step();
        end
        wt = 1'b0; ready = 1'b1; redir = 1'b0;
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
